// File: rtl/adc_line_tx_if.sv
// Sample stream into the ADC line transmitter.
// Valid/ready: a sample transfers on a CLK edge where SVALID && SREADY; SDATA must be stable while SVALID is high, and SREADY does not depend on SVALID.
interface adc_line_tx_if;
  logic [11:0] SDATA;
  logic        SVALID;
  logic        SREADY;

  modport master (output SDATA, output SVALID, input SREADY);
  modport slave  (input SDATA, input SVALID, output SREADY);
endinterface

// File: rtl/adc_line_tx.sv
// ADC-format line emulator: buffers 12-bit samples and emits 6-bit data/frame words with a bit-slip stage.
// Define ADC_LINE_TX_PRBS_EN to build the PRBS-7 source on MODE=11 (otherwise MODE=11 acts as IDLE).
module adc_line_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] TRAIN_PAT  = 6'b111000,
  parameter logic [5:0] IDLE_WORD  = 6'b000000
) (
  input  logic         CLK,
  input  logic         RST,
  adc_line_tx_if.slave s_if,
  input  logic [1:0]   MODE,
  input  logic         SLIP,
  input  logic         UCLR,
  output logic [5:0]   DOUT,
  output logic [5:0]   FOUT,
  output logic         UNDERRUN,
  output logic [5:0]   DBG_STATE
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_TRAIN = 2'b01,
    MODE_DATA  = 2'b10,
    MODE_PRBS  = 2'b11
  } mode_e;

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [11:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;
  logic [2:0]    k_q, k_d;
  mode_e         mode_q, mode_d;
  logic [5:0]    lo_q, lo_d;
  logic          und_q, und_d;
  logic [5:0]    w_q, w_d;
  logic [5:0]    f_q, f_d;
  logic [5:0]    cur_q, cur_d;
  logic [5:0]    prev_q, prev_d;
  logic [5:0]    fcur_q, fcur_d;
  logic [5:0]    fprev_q, fprev_d;
  logic [5:0]    dout_q, dout_d;
  logic [5:0]    fout_q, fout_d;
  logic          underrun_q, underrun_d;
`ifdef ADC_LINE_TX_PRBS_EN
  logic [6:0]    lfsr_q, lfsr_d;
`endif

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  mode_e         mode_in;
  mode_e         mode_eff;
  logic [11:0]   h;
  logic [11:0]   fh;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign s_if.SREADY = !full;
  assign push        = s_if.SVALID && !full;
  assign mode_in     = mode_e'(MODE);
  // Phase 0 edges latch MODE, so both halves of a sample see the same mode.
  assign mode_eff    = phase_q ? mode_q : mode_in;

`ifdef ADC_LINE_TX_PRBS_EN
  // Six steps of x^7+x^6+1; the first generated bit lands in word bit 5.
  function automatic logic [12:0] prbs6(input logic [6:0] seed);
    logic [6:0] st;
    logic [5:0] w;
    logic       nb;
    st = seed;
    w  = '0;
    for (int i = 0; i < 6; i++) begin
      nb = st[6] ^ st[5];
      w  = {w[4:0], nb};
      st = {st[5:0], nb};
    end
    return {st, w};
  endfunction
`endif

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    phase_d    = ~phase_q;
    mode_d     = phase_q ? mode_q : mode_in;
    lo_d       = lo_q;
    und_d      = und_q;
    w_d        = IDLE_WORD;
    f_d        = phase_q ? 6'b000000 : 6'b111111;
    underrun_d = underrun_q;
    pop        = 1'b0;
`ifdef ADC_LINE_TX_PRBS_EN
    lfsr_d     = lfsr_q;
`endif

    case (mode_eff)
      MODE_DATA: begin
        if (!phase_q) begin
          if (!empty) begin
            pop   = 1'b1;
            w_d   = mem_q[rd_ptr_q][11:6];
            lo_d  = mem_q[rd_ptr_q][5:0];
            und_d = 1'b0;
          end else begin
            und_d = 1'b1;
          end
        end else begin
          w_d = und_q ? IDLE_WORD : lo_q;
        end
      end
      MODE_TRAIN: w_d = TRAIN_PAT;
`ifdef ADC_LINE_TX_PRBS_EN
      MODE_PRBS: begin
        {lfsr_d, w_d} = prbs6((!phase_q && (mode_q != MODE_PRBS)) ? 7'h7F : lfsr_q);
      end
`endif
      default: w_d = IDLE_WORD;
    endcase

    if (!phase_q && (mode_eff == MODE_DATA) && empty) begin
      underrun_d = 1'b1;
    end else if (UCLR) begin
      underrun_d = 1'b0;
    end

    if (push) begin
      mem_d[wr_ptr_q] = s_if.SDATA;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    cur_d   = w_q;
    prev_d  = cur_q;
    fcur_d  = f_q;
    fprev_d = fcur_q;
    // Window into the two-word history: k bits of extra delay.
    h       = {prev_q, cur_q} >> k_q;
    fh      = {fprev_q, fcur_q} >> k_q;
    dout_d  = h[5:0];
    fout_d  = fh[5:0];

    k_d = k_q;
    if (SLIP) begin
      k_d = (k_q == 3'd5) ? 3'd0 : k_q + 3'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= 1'b0;
      k_q        <= 3'd0;
      mode_q     <= MODE_IDLE;
      lo_q       <= '0;
      und_q      <= 1'b0;
      w_q        <= '0;
      f_q        <= '0;
      cur_q      <= '0;
      prev_q     <= '0;
      fcur_q     <= '0;
      fprev_q    <= '0;
      dout_q     <= '0;
      fout_q     <= '0;
      underrun_q <= 1'b0;
`ifdef ADC_LINE_TX_PRBS_EN
      lfsr_q     <= 7'h7F;
`endif
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      lo_q       <= lo_d;
      und_q      <= und_d;
      w_q        <= w_d;
      f_q        <= f_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      fcur_q     <= fcur_d;
      fprev_q    <= fprev_d;
      dout_q     <= dout_d;
      fout_q     <= fout_d;
      underrun_q <= underrun_d;
`ifdef ADC_LINE_TX_PRBS_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign DOUT      = dout_q;
  assign FOUT      = fout_q;
  assign UNDERRUN  = underrun_q;
  assign DBG_STATE = {mode_q, phase_q, k_q};

endmodule

// File: tb/tb_adc_line_tx.sv
// Bench for adc_line_tx: directed vector table, hand sequences and a randomized run against a word-stream model.
`timescale 1ns/1ps
module tb_adc_line_tx;

  localparam int         DEPTH = 4;
  localparam logic [5:0] TRAIN = 6'b111000;
  localparam logic [5:0] IDLE  = 6'b000000;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] MODE;
  logic       SLIP;
  logic       UCLR;
  logic [5:0] DOUT;
  logic [5:0] FOUT;
  logic       UNDERRUN;
  logic [5:0] DBG_STATE;

  adc_line_tx_if s_if();

  adc_line_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .s_if      (s_if),
    .MODE      (MODE),
    .SLIP      (SLIP),
    .UCLR      (UCLR),
    .DOUT      (DOUT),
    .FOUT      (FOUT),
    .UNDERRUN  (UNDERRUN),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The line is a stream of 6-bit words; DOUT shows that stream two words
  // late, further delayed by k bits taken from the older word.
  logic [11:0] m_q[$];
  int          m_e;
  logic [1:0]  m_mode;
  logic [5:0]  m_lo;
  bit          m_und;
  bit          m_underrun;
  int          m_k;
  logic [5:0]  w1, w2, w3, f1, f2, f3;
  logic [5:0]  m_dout, m_fout;
  int          prbs_pos;
  bit          prbs_seq[127];

  task automatic model_reset();
    m_q.delete();
    m_e = 0; m_mode = 2'b00; m_lo = '0; m_und = 0; m_underrun = 0; m_k = 0;
    w1 = '0; w2 = '0; w3 = '0; f1 = '0; f2 = '0; f3 = '0;
    m_dout = '0; m_fout = '0; prbs_pos = 0;
  endtask

  task automatic model_edge(input logic [1:0] mode, input bit sv, input logic [11:0] sd,
                            input bit slip, input bit uclr);
    int          ph;
    logic [1:0]  eff;
    logic [5:0]  w, f;
    logic [11:0] s, hw, hf;
    bit          push, was_empty;
    ph        = m_e % 2;
    push      = sv && (m_q.size() < DEPTH);
    was_empty = (m_q.size() == 0);
    eff       = (ph == 0) ? mode : m_mode;
    w         = IDLE;
    if (eff == 2'b10) begin
      if (ph == 0) begin
        if (!was_empty) begin
          s = m_q.pop_front(); w = s[11:6]; m_lo = s[5:0]; m_und = 0;
        end else begin
          m_und = 1;
        end
      end else begin
        w = m_und ? IDLE : m_lo;
      end
    end else if (eff == 2'b01) begin
      w = TRAIN;
    end
`ifdef ADC_LINE_TX_PRBS_EN
    else if (eff == 2'b11) begin
      if (ph == 0 && m_mode != 2'b11) prbs_pos = 0;
      for (int i = 0; i < 6; i++) begin
        w = {w[4:0], prbs_seq[prbs_pos]};
        prbs_pos = (prbs_pos + 1) % 127;
      end
    end
`endif
    if (ph == 0 && eff == 2'b10 && was_empty) m_underrun = 1;
    else if (uclr) m_underrun = 0;
    f  = (ph == 0) ? 6'h3F : 6'h00;
    hw = {w3, w2} >> m_k;
    hf = {f3, f2} >> m_k;
    m_dout = hw[5:0];
    m_fout = hf[5:0];
    w3 = w2; w2 = w1; w1 = w;
    f3 = f2; f2 = f1; f1 = f;
    if (push) m_q.push_back(sd);
    if (slip) m_k = (m_k + 1) % 6;
    if (ph == 0) m_mode = mode;
    m_e++;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    RST = 1'b1; MODE = 2'b00; SLIP = 1'b0; UCLR = 1'b0;
    s_if.SVALID = 1'b0; s_if.SDATA = '0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [1:0] mode, input bit sv, input logic [11:0] sd,
                      input bit slip, input bit uclr);
    MODE = mode; s_if.SVALID = sv; s_if.SDATA = sd; SLIP = slip; UCLR = uclr;
    @(posedge CLK);
    model_edge(mode, sv, sd, slip, uclr);
    @(negedge CLK);
    check("model_dout", 12'(DOUT), 12'(m_dout));
    check("model_fout", 12'(FOUT), 12'(m_fout));
    check("model_underrun", 12'(UNDERRUN), 12'(m_underrun));
    check("model_sready", 12'(s_if.SREADY), 12'(m_q.size() < DEPTH));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    bit          sv;
    logic [11:0] sd;
    bit          uclr;
    bit          chk;
    logic [5:0]  dout;
    logic [5:0]  fout;
    bit          und;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit          b[134];
    logic [11:0] pushed[$];
    logic [5:0]  word, first_word;
    logic [11:0] sd;
    int          n_acc;

    for (int i = 0; i < 7; i++) b[i] = 1;
    for (int n = 7; n < 134; n++) b[n] = b[n-6] ^ b[n-7];
    for (int i = 0; i < 127; i++) prbs_seq[i] = b[i+7];

    // two samples loaded in IDLE, drained in DATA, then underrun/UCLR priority
    tbl[0]  = '{2'b00, 1, 12'hABC, 0, 0, 6'h00, 6'h00, 0};
    tbl[1]  = '{2'b00, 1, 12'h123, 0, 0, 6'h00, 6'h00, 0};
    tbl[2]  = '{2'b10, 0, 12'h000, 0, 0, 6'h00, 6'h00, 0};
    tbl[3]  = '{2'b10, 0, 12'h000, 0, 0, 6'h00, 6'h00, 0};
    tbl[4]  = '{2'b10, 0, 12'h000, 0, 1, 6'h2A, 6'h3F, 0};
    tbl[5]  = '{2'b10, 0, 12'h000, 0, 1, 6'h3C, 6'h00, 0};
    tbl[6]  = '{2'b00, 0, 12'h000, 0, 1, 6'h04, 6'h3F, 0};
    tbl[7]  = '{2'b00, 0, 12'h000, 0, 1, 6'h23, 6'h00, 0};
    tbl[8]  = '{2'b10, 0, 12'h000, 0, 1, 6'h00, 6'h3F, 1};
    tbl[9]  = '{2'b10, 0, 12'h000, 0, 1, 6'h00, 6'h00, 1};
    tbl[10] = '{2'b10, 0, 12'h000, 1, 1, 6'h00, 6'h3F, 1};
    tbl[11] = '{2'b10, 0, 12'h000, 1, 1, 6'h00, 6'h00, 0};
    tbl[12] = '{2'b00, 0, 12'h000, 0, 1, 6'h00, 6'h3F, 0};

    // reset values
    do_reset();
    check("rst_dout", 12'(DOUT), 12'h0);
    check("rst_fout", 12'(FOUT), 12'h0);
    check("rst_underrun", 12'(UNDERRUN), 12'h0);
    check("rst_sready", 12'(s_if.SREADY), 12'h1);
    check("rst_dbg", 12'(DBG_STATE), 12'h0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].mode, tbl[i].sv, tbl[i].sd, 1'b0, tbl[i].uclr);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_dout", i), 12'(DOUT), 12'(tbl[i].dout));
        check($sformatf("tbl%0d_fout", i), 12'(FOUT), 12'(tbl[i].fout));
        check($sformatf("tbl%0d_underrun", i), 12'(UNDERRUN), 12'(tbl[i].und));
      end
    end

    // fill the FIFO while idle, then drain it in DATA mode
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      sd = 12'($urandom_range(0, 4095));
      if (n_acc < DEPTH) begin
        pushed.push_back(sd);
        n_acc++;
      end
      step(2'b00, 1'b1, sd, 1'b0, 1'b0);
    end
    check("full_sready", 12'(s_if.SREADY), 12'h0);
    foreach (pushed[i]) begin
      exp_q.push_back(pushed[i][11:6]);
      exp_q.push_back(pushed[i][5:0]);
    end
    step(2'b10, 1'b0, 12'h0, 1'b0, 1'b0);
    check("first_pop_sready", 12'(s_if.SREADY), 12'h1);
    for (int i = 1; i < 10; i++) begin
      step((i < 8) ? 2'b10 : 2'b00, 1'b0, 12'h0, 1'b0, 1'b0);
      if (i >= 2) begin
        word = exp_q.pop_front();
        check($sformatf("drain_word%0d", i - 2), 12'(DOUT), 12'(word));
      end
    end
    check("drain_underrun", 12'(UNDERRUN), 12'h0);

    // TRAIN with bit slip, including wrap of k
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b01, 1'b0, 12'h0, 1'b0, 1'b0);
    check("train_k0", 12'(DOUT), 12'(TRAIN));
    step(2'b01, 1'b0, 12'h0, 1'b1, 1'b0);
    step(2'b01, 1'b0, 12'h0, 1'b0, 1'b0);
    check("train_k1", 12'(DOUT), 12'(6'b011100));
    for (int i = 0; i < 5; i++) step(2'b01, 1'b0, 12'h0, 1'b1, 1'b0);
    step(2'b01, 1'b0, 12'h0, 1'b0, 1'b0);
    check("train_wrap", 12'(DOUT), 12'(TRAIN));

    // asynchronous reset mid-sample with three buffered samples
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 12'($urandom_range(1, 4095)), (i == 0), 1'b0);
    step(2'b10, 1'b0, 12'h0, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("arst_dout", 12'(DOUT), 12'h0);
    check("arst_fout", 12'(FOUT), 12'h0);
    check("arst_sready", 12'(s_if.SREADY), 12'h1);
    check("arst_k", 12'(DBG_STATE[2:0]), 12'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    step(2'b10, 1'b0, 12'h0, 1'b0, 1'b0);
    check("arst_fifo_empty", 12'(UNDERRUN), 12'h1);

    // MODE=11
    do_reset();
`ifdef ADC_LINE_TX_PRBS_EN
    first_word = '0;
    for (int i = 0; i < 6; i++) first_word = {first_word[4:0], prbs_seq[i]};
    for (int i = 0; i < 130; i++) begin
      step(2'b11, 1'b0, 12'h0, 1'b0, 1'b0);
      if (i == 2) check("prbs_first", 12'(DOUT), 12'(first_word));
      if (i == 129) check("prbs_period", 12'(DOUT), 12'(first_word));
    end
`else
    for (int i = 0; i < 4; i++) step(2'b11, 1'b0, 12'h0, 1'b0, 1'b0);
    check("mode11_idle", 12'(DOUT), 12'(IDLE));
`endif

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
           $urandom_range(0, 3) != 0,
           12'($urandom_range(0, 4095)),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_line_tx.md
Name: adc_line_tx

Overview:
- Fabric-side transmitter for one ADC-format serial line: the counterpart of the per-line 6-bit DDR deserializer.
- Buffers 12-bit samples and emits one 6-bit word per CLK, plus a matching frame-line word, to an external 6:1 output serializer pair.
- Used as an on-board ADC emulator for loopback testing of the receive chain, including its delay and bitslip alignment logic.

Parameters:
FIFO_DEPTH, 4, sample buffer depth (power of two, 2..16)
TRAIN_PAT, 6'b111000, word sent every cycle in TRAIN mode
IDLE_WORD, 6'b000000, word sent in IDLE mode and on underrun

Ports:
CLK  in  1  general FPGA clock; one 6-bit word per cycle
RST  in  1  asynchronous reset, active-high
MODE  in  2  00 IDLE, 01 TRAIN, 10 DATA, 11 PRBS (see Optional Feature)
SDATA  in  12  sample to transmit
SVALID  in  1  SDATA valid
SREADY  out  1  FIFO can accept (=!full)
SLIP  in  1  one-cycle pulse: delay the emitted stream by one more bit
UCLR  in  1  clear UNDERRUN
DOUT  out  6  data word to serializer; DOUT[5] serialized first
FOUT  out  6  frame word to serializer
UNDERRUN  out  1  sticky: DATA mode found the FIFO empty at a sample boundary

Behaviour:
- Reset (async): FIFO empty, phase=0, slip offset k=0, mode register=IDLE, prev/cur words=0, DOUT=0, FOUT=0, UNDERRUN=0, PRBS state=7'h7F. SREADY=1 once reset is released.
- FIFO push: on an edge with SVALID & SREADY. There is no fall-through, so a word pushed at edge N is poppable from edge N+1 at the earliest.
- Phase toggles every cycle (0,1,0,...). MODE is sampled into the mode register only on edges where phase=0, so a mode change takes effect at a sample boundary and never splits a sample.
- Stage-1 word W:
  - DATA, phase 0, FIFO non-empty: pop and hold sample S; W=S[11:6].
  - DATA, phase 1: W=S[5:0].
  - DATA, phase 0, FIFO empty: W=IDLE_WORD, and phase 1 also sends IDLE_WORD; UNDERRUN is set.
  - TRAIN: W=TRAIN_PAT.
  - IDLE: W=IDLE_WORD.
  - FIFO is popped only in DATA mode and is never flushed by mode changes.
- Frame word F=6'b111111 in phase 0, 6'b000000 in phase 1, in all modes.
- Slip stage: registers cur<=W and prev<=cur (and likewise for the frame path). Output H={prev,cur} (12 bits); DOUT<=H[5+k:k], FOUT likewise with the same k.
  - k=1 gives {prev[0],cur[5:1]}, i.e. one-bit delay.
  - SLIP increments k mod 6 (5 wraps to 0). The new k applies from the edge after the pulse.
- Latency: a sample popped at edge P shows S[11:6] on DOUT after edge P+2 with k=0, and S[5:0] after P+3.
- UNDERRUN: set has priority over UCLR in the same cycle; it is held until UCLR.
- Full FIFO with a simultaneous pop: SREADY was low, so no push occurs; SREADY rises after that edge.
- RST asserted mid-stream: everything returns to reset values immediately and buffered samples are discarded.

Optional Feature:
ADC_LINE_TX_PRBS_EN:
- Defined: MODE=11 emits PRBS-7 (x^7+x^6+1), advancing 6 bits per CLK with MSB-first bit order; the generator runs only in this mode. Seed 7'h7F on reset and whenever the mode register enters PRBS.
- Undefined: MODE=11 behaves exactly as IDLE and no LFSR logic is built.

Test Plan:
1. Reset, MODE=10, push 12'hABC then 12'h123 -> DOUT sequence 6'h2A, 6'h3C, 6'h04, 6'h23 on consecutive cycles, FOUT 3F/00 alternating, UNDERRUN=0.
2. MODE=10 with FIFO empty -> DOUT=IDLE_WORD, UNDERRUN=1. Then UCLR pulse and an empty boundary in the same cycle -> UNDERRUN stays 1.
3. Hold SVALID=1 with MODE=00 -> exactly FIFO_DEPTH (4) pushes, then SREADY=0. Switch to DATA -> SREADY=1 one cycle after the first pop, and all 4 samples come out in order.
4. MODE=01, k=0 -> DOUT=6'b111000 every cycle. One SLIP pulse -> 6'b011100. Six pulses total -> 6'b111000 again (wrap). FOUT shifts identically.
5. RST asserted mid-sample with FIFO holding 3 entries -> DOUT=0, FOUT=0, SREADY=1, FIFO empty, k=0 immediately.
6. (PRBS_EN) MODE=11 after reset -> first DOUT equals the first 6 PRBS-7 bits from seed 7F, and the sequence repeats every 127 bits. Without the macro -> DOUT=IDLE_WORD.
